// File: rtl/uart_pkg.sv
// uart_pkg: byte width and byte type shared by the UART receiver, transmitter and FIFOs
package uart_pkg;
   localparam int UART_DATA_W = 8;
   typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x byte register array, one synchronous write port, one asynchronous read port, no reset
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_Clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  uart_byte_t        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output uart_byte_t        rd_data
);
   uart_byte_t mem [DEPTH];
   assign rd_data = mem[rd_addr];
   // store the incoming byte at the write address
   always_ff @(posedge i_Clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with FWFT valid/ready output, fill status, sticky overflow; idle timeout under UART_RX_FIFO_TIMEOUT_EN
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int AFULL_LEVEL  = 12,
   parameter int CLKS_PER_BIT = 217,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic                     i_Clock,
   input  logic                     i_Rst_L,
   input  logic                     i_RX_DV,
   input  uart_byte_t               i_RX_Byte,
   output uart_byte_t               o_Data,
   output logic                     o_Valid,
   input  logic                     i_Ready,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Empty,
   output logic                     o_Full,
   output logic                     o_Almost_Full,
   output logic                     o_Overflow,
   input  logic                     i_Overflow_Clr,
   output logic                     o_Timeout
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CW     = ADDR_W + 1;
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) $error("uart_rx_fifo: DEPTH must be a power of 2 >= 2");
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) $error("uart_rx_fifo: AFULL_LEVEL out of range");
   if (CLKS_PER_BIT < 1 || TIMEOUT_BITS < 1) $error("uart_rx_fifo: timeout parameters must be positive");
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   uart_byte_t        rd_data;
   logic              push, pop;
   assign pop           = o_Valid && i_Ready;
   assign push          = i_RX_DV && (!o_Full || pop);
   assign o_Valid       = o_Count != '0;
   assign o_Empty       = !o_Valid;
   assign o_Full        = o_Count == CW'(DEPTH);
   assign o_Almost_Full = o_Count >= CW'(AFULL_LEVEL);
   assign o_Data        = o_Valid ? rd_data : '0;
   uart_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .i_Clock (i_Clock),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (i_RX_Byte),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );
   // advance pointers on push/pop; occupancy moves only when exactly one of them happens
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_Count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push != pop) o_Count <= push ? o_Count + CW'(1) : o_Count - CW'(1);
      end
   end
   // sticky drop flag; a new drop outranks a clear in the same cycle
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) o_Overflow <= 1'b0;
      else if (i_RX_DV && o_Full && !pop) o_Overflow <= 1'b1;
      else if (i_Overflow_Clr) o_Overflow <= 1'b0;
   end
`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W   = $clog2(TO_MAX + 1);
   logic [TO_W-1:0] idle_cnt;
   assign o_Timeout = (idle_cnt == TO_W'(TO_MAX)) && !o_Empty;
   // count idle cycles while data waits; any traffic or an empty FIFO restarts it
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) idle_cnt <= '0;
      else if (push || pop || o_Empty) idle_cnt <= '0;
      else if (idle_cnt != TO_W'(TO_MAX)) idle_cnt <= idle_cnt + TO_W'(1);
   end
`else
   assign o_Timeout = 1'b0;
`endif
endmodule
